// File: rtl/layer0_feeder_if.sv
// Result-stream bundle between the layer-0 feeder and its image memory / pooling receiver.
// o_valid is a one-cycle strobe with no ready: the receiver must take every beat; i_go_down releases the next band.
interface layer0_feeder_if;
    logic        i_start;
    logic        o_busy;
    logic        o_done;
    logic [11:0] o_iaddr;
    logic [19:0] i_idata;
    logic        o_valid;
    logic [18:0] o_data_0;
    logic [18:0] o_data_1;
    logic        i_go_down;
    logic [2:0]  o_dbg_state;

    modport master (
        input  i_start, i_idata, i_go_down,
        output o_busy, o_done, o_iaddr, o_valid, o_data_0, o_data_1, o_dbg_state
    );

    modport slave (
        output i_start, i_idata, i_go_down,
        input  o_busy, o_done, o_iaddr, o_valid, o_data_0, o_data_1, o_dbg_state
    );
endinterface

// File: rtl/layer0_feeder.sv
// Layer-0 producer: two 3x3 zero-padded convolutions with bias and ReLU over a 64x64 image,
// streamed as 32 bands of 128 beats, each band released by the receiver's go_down pulse.
module layer0_feeder (
    input  logic            clk,
    input  logic            reset,
    layer0_feeder_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_ROUND     = 3'd2,
        S_EMIT      = 3'd3,
        S_WAIT_DOWN = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [19:0] BIAS0 = 20'h01310;
    localparam logic [19:0] BIAS1 = 20'hF7295;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_tap, w_tap_nxt;
    logic [4:0]  r_band, w_band_nxt;
    logic [6:0]  r_pix, w_pix_nxt;
    logic        r_pend, r_ok, r_dok;
    logic [43:0] r_acc0, r_acc1;
    logic        r_busy, r_done, r_valid;
    logic [11:0] r_iaddr;
    logic [18:0] r_data0, r_data1;

    logic        w_go, w_enter_fetch, w_adv_band, w_ok, w_load_addr;
    logic [7:0]  w_dr, w_dc, w_tr, w_tc;
    logic [19:0] w_d, w_c0, w_c1, w_v0, w_v1, w_b0, w_b1;
    logic [39:0] w_prod0, w_prod1;
    logic [18:0] w_out0, w_out1;

    function automatic logic [19:0] coef0(input logic [3:0] k);
        case (k)
            4'd0: coef0 = 20'h0A89E;  4'd1: coef0 = 20'h092D5;  4'd2: coef0 = 20'h06D43;
            4'd3: coef0 = 20'h01004;  4'd4: coef0 = 20'hF8F71;  4'd5: coef0 = 20'hF6E54;
            4'd6: coef0 = 20'hFA6D7;  4'd7: coef0 = 20'hFC834;  4'd8: coef0 = 20'hFAC19;
            default: coef0 = 20'h00000;
        endcase
    endfunction

    function automatic logic [19:0] coef1(input logic [3:0] k);
        case (k)
            4'd0: coef1 = 20'hFDB55;  4'd1: coef1 = 20'h02992;  4'd2: coef1 = 20'hFC994;
            4'd3: coef1 = 20'h050FD;  4'd4: coef1 = 20'h02F20;  4'd5: coef1 = 20'h0202D;
            4'd6: coef1 = 20'h03BD7;  4'd7: coef1 = 20'hFD369;  4'd8: coef1 = 20'h05E68;
            default: coef1 = 20'h00000;
        endcase
    endfunction

    assign w_go = r_pend | bus.i_go_down;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (bus.i_start) w_state_nxt = S_FETCH;
            S_FETCH:     if (r_tap == 4'd9) w_state_nxt = S_ROUND;
            S_ROUND:     w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (r_pix != 7'd127)      w_state_nxt = S_FETCH;
                else if (r_band == 5'd31) w_state_nxt = S_DONE;
                else if (w_go)            w_state_nxt = S_FETCH;
                else                      w_state_nxt = S_WAIT_DOWN;
            end
            S_WAIT_DOWN: if (w_go) w_state_nxt = S_FETCH;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_enter_fetch = (w_state_nxt == S_FETCH) && (r_state != S_FETCH);
        w_adv_band    = w_enter_fetch &&
                        (((r_state == S_EMIT) && (r_pix == 7'd127)) || (r_state == S_WAIT_DOWN));
        w_tap_nxt     = w_enter_fetch ? 4'd0 : r_tap + 4'd1;
        w_band_nxt    = r_band;
        w_pix_nxt     = r_pix;
        if (w_enter_fetch) begin
            if (r_state == S_IDLE) begin
                w_band_nxt = 5'd0;
                w_pix_nxt  = 7'd0;
            end else if (w_adv_band) begin
                w_band_nxt = r_band + 5'd1;
                w_pix_nxt  = 7'd0;
            end else begin
                w_pix_nxt  = r_pix + 7'd1;
            end
        end

        // Tap k sits at (row + k/3 - 1, col + k%3 - 1); 8-bit wrap makes -1 and 64 both show in bits [7:6].
        if (w_tap_nxt < 4'd3)      w_dr = 8'hFF;
        else if (w_tap_nxt < 4'd6) w_dr = 8'h00;
        else                       w_dr = 8'h01;
        case (w_tap_nxt)
            4'd0, 4'd3, 4'd6: w_dc = 8'hFF;
            4'd1, 4'd4, 4'd7: w_dc = 8'h00;
            default:          w_dc = 8'h01;
        endcase
        w_tr        = {2'b00, w_band_nxt, w_pix_nxt[6]} + w_dr;
        w_tc        = {2'b00, w_pix_nxt[5:0]} + w_dc;
        w_ok        = (w_tr[7:6] == 2'b00) && (w_tc[7:6] == 2'b00);
        w_load_addr = (w_state_nxt == S_FETCH) && (w_tap_nxt <= 4'd8);

        // Data returning in FETCH cycle t belongs to tap t-1; padded taps contribute zero.
        w_d     = r_dok ? bus.i_idata : 20'h00000;
        w_c0    = coef0(r_tap - 4'd1);
        w_c1    = coef1(r_tap - 4'd1);
        w_prod0 = {{20{w_d[19]}}, w_d} * {{20{w_c0[19]}}, w_c0};
        w_prod1 = {{20{w_d[19]}}, w_d} * {{20{w_c1[19]}}, w_c1};

        w_v0   = r_acc0[35:16] + {19'd0, r_acc0[15]};
        w_v1   = r_acc1[35:16] + {19'd0, r_acc1[15]};
        w_b0   = w_v0 + BIAS0;
        w_b1   = w_v1 + BIAS1;
        w_out0 = w_b0[19] ? 19'd0 : w_b0[18:0];
        w_out1 = w_b1[19] ? 19'd0 : w_b1[18:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tap   <= 4'd0;
            r_band  <= 5'd0;
            r_pix   <= 7'd0;
            r_pend  <= 1'b0;
            r_ok    <= 1'b0;
            r_dok   <= 1'b0;
            r_acc0  <= 44'd0;
            r_acc1  <= 44'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_iaddr <= 12'd0;
            r_data0 <= 19'd0;
            r_data1 <= 19'd0;
        end else begin
            r_tap  <= (w_state_nxt == S_FETCH) ? w_tap_nxt : 4'd0;
            r_band <= w_band_nxt;
            r_pix  <= w_pix_nxt;
            r_dok  <= r_ok;
            if (w_load_addr) begin
                r_ok <= w_ok;
                if (w_ok) r_iaddr <= {w_tr[5:0], w_tc[5:0]};
            end

            if (w_enter_fetch) begin
                r_acc0 <= 44'd0;
                r_acc1 <= 44'd0;
            end else if ((r_state == S_FETCH) && (r_tap != 4'd0)) begin
                r_acc0 <= r_acc0 + {{4{w_prod0[39]}}, w_prod0};
                r_acc1 <= r_acc1 + {{4{w_prod1[39]}}, w_prod1};
            end

            // One-deep early release; a pulse arriving while one is already pending is dropped.
            if (w_adv_band || (r_state == S_IDLE) || (r_state == S_DONE))
                r_pend <= 1'b0;
            else if (bus.i_go_down && (r_state != S_WAIT_DOWN))
                r_pend <= 1'b1;

            r_busy  <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_ROUND) ||
                       (w_state_nxt == S_EMIT)  || (w_state_nxt == S_WAIT_DOWN);
            r_done  <= (w_state_nxt == S_DONE);
            r_valid <= (w_state_nxt == S_EMIT);
            if (r_state == S_ROUND) begin
                r_data0 <= w_out0;
                r_data1 <= w_out1;
            end
        end
    end

    assign bus.o_busy      = r_busy;
    assign bus.o_done      = r_done;
    assign bus.o_valid     = r_valid;
    assign bus.o_iaddr     = r_iaddr;
    assign bus.o_data_0    = r_data0;
    assign bus.o_data_1    = r_data1;
    assign bus.o_dbg_state = r_state;
endmodule

// File: tb/tb_layer0_feeder.sv
// Bench for layer0_feeder: image memory model, golden convolution model and per-scenario tasks.
module tb_layer0_feeder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    layer0_feeder_if bus ();
    layer0_feeder dut (.clk(clk), .reset(reset), .bus(bus));

    logic [19:0] img [4096];
    logic [19:0] mem_q = 20'd0;
    always @(posedge clk) mem_q <= img[bus.o_iaddr];
    assign bus.i_idata = mem_q;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [37:0] exp_q [$];

    int kcoef [2][9] = '{'{'h0A89E, 'h092D5, 'h06D43, 'h01004, 'hF8F71, 'hF6E54, 'hFA6D7, 'hFC834, 'hFAC19},
                         '{'hFDB55, 'h02992, 'hFC994, 'h050FD, 'h02F20, 'h0202D, 'h03BD7, 'hFD369, 'h05E68}};
    int kbias [2] = '{'h01310, 'hF7295};

    always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Reference: signed 3x3 correlation, 4.16 round-half-up, 20-bit wrap bias add, ReLU.
    function automatic logic [18:0] golden(input int r, input int c, input int kn);
        longint acc;
        longint v;
        longint cf;
        acc = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (r + dr >= 0 && r + dr < 64 && c + dc >= 0 && c + dc < 64) begin
                    cf = kcoef[kn][(dr + 1) * 3 + dc + 1];
                    if (cf >= 'h80000) cf -= 'h100000;
                    acc += longint'($signed(img[(r + dr) * 64 + c + dc])) * cf;
                end
            end
        end
        v = ((acc >>> 16) + ((acc >>> 15) & 1)) & 64'hFFFFF;
        v = (v + longint'(kbias[kn])) & 64'hFFFFF;
        return (v >= 'h80000) ? 19'd0 : v[18:0];
    endfunction

    function automatic void push_band(input int b);
        for (int p = 0; p < 128; p++)
            exp_q.push_back({golden(2 * b + p / 64, p % 64, 0), golden(2 * b + p / 64, p % 64, 1)});
    endfunction

    task automatic wait_valid(input int budget, output int waited, output bit seen);
        seen = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (bus.o_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_go_down();
        bus.i_go_down = 1'b1;
        @(negedge clk);
        bus.i_go_down = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.o_busy, bus.o_done, bus.o_valid} !== 3'b000)
            $display("FAIL reset_flags: got %b required 000", {bus.o_busy, bus.o_done, bus.o_valid});
        else n_pass++;
        n_checks++;
        if ({bus.o_iaddr, bus.o_data_0, bus.o_data_1} !== 50'd0)
            $display("FAIL reset_bus: iaddr %h d0 %h d1 %h required 0", bus.o_iaddr, bus.o_data_0, bus.o_data_1);
        else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timing_and_reset();
        int exp_addr [10] = '{0, 'h000, 'h000, 'h000, 'h000, 'h000, 'h001, 'h001, 'h040, 'h041};
        int viol;
        int gap;
        bit seen;
        logic [37:0] e;
        for (int i = 0; i < 4096; i++) img[i] = 20'd0;
        img[0] = 20'h10000;
        pulse_go_down();
        push_band(0);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        n_checks++;
        if (bus.o_busy !== 1'b1) $display("FAIL busy_after_start: got %b required 1", bus.o_busy);
        else n_pass++;
        viol = 0;
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.o_valid === 1'b1) viol++;
            if (k <= 9) begin
                n_checks++;
                if (bus.o_iaddr !== 12'(exp_addr[k]))
                    $display("FAIL tap_addr_%0d: got %h required %h", k - 1, bus.o_iaddr, 12'(exp_addr[k]));
                else n_pass++;
            end
        end
        n_checks++;
        if (viol != 0) $display("FAIL early_valid: got %0d strobes before cycle 12 required 0", viol);
        else n_pass++;
        @(negedge clk);
        for (int j = 0; j < 128; j++) begin
            if (j == 0) begin
                gap = 12;
                seen = (bus.o_valid === 1'b1);
            end else begin
                wait_valid(20, gap, seen);
            end
            n_checks++;
            if (!seen || gap != 12) begin
                $display("FAIL band0_beat_gap_%0d: got %0d cycles (seen %0d) required 12", j, gap, seen);
                return;
            end else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.o_data_0, bus.o_data_1} !== e)
                $display("FAIL band0_data_%0d: got %h/%h required %h/%h", j, bus.o_data_0, bus.o_data_1, e[37:19], e[18:0]);
            else n_pass++;
        end
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) viol++;
        end
        n_checks++;
        if (viol != 0 || bus.o_busy !== 1'b1)
            $display("FAIL band_hold: got %0d strobes busy %b required 0 strobes busy 1", viol, bus.o_busy);
        else n_pass++;
        push_band(1);
        pulse_go_down();
        for (int j = 0; j < 50; j++) begin
            wait_valid(20, gap, seen);
            n_checks++;
            if (!seen || gap != ((j == 0) ? 11 : 12)) begin
                $display("FAIL band1_beat_gap_%0d: got %0d cycles (seen %0d) required %0d", j, gap, seen, (j == 0) ? 11 : 12);
                return;
            end else n_pass++;
            e = exp_q.pop_front();
            n_checks++;
            if ({bus.o_data_0, bus.o_data_1} !== e)
                $display("FAIL band1_data_%0d: got %h/%h required %h/%h", j, bus.o_data_0, bus.o_data_1, e[37:19], e[18:0]);
            else n_pass++;
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_busy, bus.o_done, bus.o_valid} !== 3'b000)
            $display("FAIL midreset_flags: got %b required 000", {bus.o_busy, bus.o_done, bus.o_valid});
        else n_pass++;
        n_checks++;
        if ({bus.o_iaddr, bus.o_data_0, bus.o_data_1} !== 50'd0)
            $display("FAIL midreset_bus: iaddr %h d0 %h d1 %h required 0", bus.o_iaddr, bus.o_data_0, bus.o_data_1);
        else n_pass++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        viol = 0;
        repeat (2000) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1 || bus.o_busy === 1'b1) viol++;
        end
        n_checks++;
        if (viol != 0) $display("FAIL post_reset_quiet: got %0d active cycles required 0", viol);
        else n_pass++;
    endtask

    task automatic test_early_go_down();
        int gap;
        int exp_gap;
        int viol;
        bit seen;
        for (int i = 0; i < 4096; i++) img[i] = 20'd0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        exp_gap = 11;
        for (int j = 0; j < 256; j++) begin
            wait_valid(20, gap, seen);
            n_checks++;
            if (!seen || gap != exp_gap) begin
                $display("FAIL early_gap_%0d: got %0d cycles (seen %0d) required %0d", j, gap, seen, exp_gap);
                return;
            end else n_pass++;
            n_checks++;
            if (bus.o_data_0 !== 19'h01310 || bus.o_data_1 !== 19'h00000)
                $display("FAIL zero_img_data_%0d: got %h/%h required 01310/00000", j, bus.o_data_0, bus.o_data_1);
            else n_pass++;
            exp_gap = 12;
            if (j == 10 || j == 20) begin
                pulse_go_down();
                exp_gap = 11;
            end else if (j == 30) begin
                bus.i_start = 1'b1;
                @(negedge clk);
                bus.i_start = 1'b0;
                exp_gap = 11;
            end
        end
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_valid === 1'b1) viol++;
        end
        n_checks++;
        if (viol != 0) $display("FAIL band2_waits: got %0d strobes required 0", viol);
        else n_pass++;
        pulse_go_down();
        wait_valid(20, gap, seen);
        n_checks++;
        if (!seen || gap != 11 || bus.o_data_0 !== 19'h01310)
            $display("FAIL band2_release: got gap %0d seen %0d d0 %h required 11 1 01310", gap, seen, bus.o_data_0);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_random_frame();
        int gap;
        int exp_gap;
        int idle;
        int viol;
        int done0;
        int early_at;
        bit early;
        bit seen;
        logic [37:0] e;
        for (int i = 0; i < 4096; i++) img[i] = 20'($urandom);
        done0 = done_cnt;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        exp_gap = 11;
        for (int b = 0; b < 32; b++) begin
            push_band(b);
            early = (b < 31) && ($urandom_range(0, 2) == 0);
            early_at = $urandom_range(0, 120);
            for (int j = 0; j < 128; j++) begin
                wait_valid(20, gap, seen);
                n_checks++;
                if (!seen || gap != exp_gap) begin
                    $display("FAIL rand_gap_b%0d_p%0d: got %0d cycles (seen %0d) required %0d", b, j, gap, seen, exp_gap);
                    exp_q.delete();
                    return;
                end else n_pass++;
                e = exp_q.pop_front();
                n_checks++;
                if ({bus.o_data_0, bus.o_data_1} !== e || bus.o_busy !== 1'b1)
                    $display("FAIL rand_data_b%0d_p%0d: got %h/%h busy %b required %h/%h busy 1",
                             b, j, bus.o_data_0, bus.o_data_1, bus.o_busy, e[37:19], e[18:0]);
                else n_pass++;
                exp_gap = 12;
                if (early && j == early_at) begin
                    pulse_go_down();
                    exp_gap = 11;
                end
            end
            if (b < 31 && !early) begin
                idle = $urandom_range(0, 15);
                viol = 0;
                repeat (idle) begin
                    @(negedge clk);
                    if (bus.o_valid === 1'b1) viol++;
                end
                n_checks++;
                if (viol != 0) $display("FAIL rand_wait_b%0d: got %0d strobes required 0", b, viol);
                else n_pass++;
                pulse_go_down();
                exp_gap = 11;
            end
        end
        gap = 0;
        seen = 1'b0;
        while (!seen && gap < 4) begin
            @(negedge clk);
            gap++;
            if (bus.o_done === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || gap != 1 || bus.o_busy !== 1'b0)
            $display("FAIL done_timing: got delay %0d seen %0d busy %b required 1 1 0", gap, seen, bus.o_busy);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt - done0 != 1 || bus.o_done !== 1'b0)
            $display("FAIL done_count: got %0d pulses required 1", done_cnt - done0);
        else n_pass++;
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_go_down = 1'b0;
        for (int i = 0; i < 4096; i++) img[i] = 20'd0;
        test_reset();
        test_timing_and_reset();
        test_early_go_down();
        test_random_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
